// File: rtl/f32add_rr_share.sv
// -----------------------------------------------------------------------------
// f32add_rr_share
//
// Purpose:
//   Lets NUM_REQ requesters share one external combinational f32 adder.
//   A round-robin arbiter picks one requester per cycle. Its operands are
//   registered (stage S1) and driven to the adder. The adder result is
//   registered (stage S2) and returned on a single response channel, together
//   with the requester index and the request tag.
//
//   The block never looks at operand values. NaN, Inf, zero and denormal
//   operands reach the adder unchanged, and add_out reaches rsp_data bit-exact.
//
// Optional feature:
//   Define F32ADD_RR_SHARE_STATS_EN to add two registered 32-bit counters:
//     stat_ops   - completed response handshakes
//     stat_stall - cycles with rsp_valid & !rsp_ready
//   Both counters wrap at 2^32 and clear on rst.
//
// Ports:
//   clk        in   1              rising-edge clock
//   rst        in   1              synchronous, active-high reset
//   req_valid  in   NUM_REQ        per-requester request valid
//   req_ready  out  NUM_REQ        per-requester accept (one-hot or zero)
//   req_x      in   32*NUM_REQ     operand x, requester i at [32*i +: 32]
//   req_y      in   32*NUM_REQ     operand y, same packing
//   req_tag    in   TAG_W*NUM_REQ  tag, requester i at [TAG_W*i +: TAG_W]
//   add_x      out  32             registered operand x to the shared adder
//   add_y      out  32             registered operand y to the shared adder
//   add_out    in   32             adder sum, combinational in add_x/add_y
//   rsp_valid  out  1              response valid
//   rsp_ready  in   1              response consumer ready
//   rsp_id     out  ID_W           index of the requester that issued it
//   rsp_tag    out  TAG_W          tag echoed from the request
//   rsp_data   out  32             f32 sum
//   stat_ops   out  32             (STATS_EN only) response handshakes
//   stat_stall out  32             (STATS_EN only) backpressured cycles
//
// Handshake semantics (request and response channels alike):
//   A transfer happens on a rising edge where valid and ready are both high.
//   The producer holds valid and its payload stable until that transfer
//   happens. ready may depend combinationally on valid. valid never depends
//   on ready.
// -----------------------------------------------------------------------------
module f32add_rr_share #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [32*NUM_REQ-1:0]    req_x,
    input  logic [32*NUM_REQ-1:0]    req_y,
    input  logic [TAG_W*NUM_REQ-1:0] req_tag,
    output logic [31:0]              add_x,
    output logic [31:0]              add_y,
    input  logic [31:0]              add_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [TAG_W-1:0]         rsp_tag,
    output logic [31:0]              rsp_data
`ifdef F32ADD_RR_SHARE_STATS_EN
    ,
    output logic [31:0]              stat_ops,
    output logic [31:0]              stat_stall
`endif
);

    // One extra bit so that ptr + offset can be reduced modulo NUM_REQ
    // without overflowing, even at NUM_REQ = 16.
    localparam int IW1 = ID_W + 1;

    // ---------------------------------------------------------------------
    // Pipeline state
    // ---------------------------------------------------------------------
    logic              s1_valid;
    logic [31:0]       s1_x;
    logic [31:0]       s1_y;
    logic [ID_W-1:0]   s1_id;
    logic [TAG_W-1:0]  s1_tag;

    logic [ID_W-1:0]   ptr;

    logic              s2_adv;
    logic              s1_adv;
    logic              accept;

    // S2 can take a new value when it is empty or is being drained this
    // cycle. S1 can take a new request when it is empty or is moving into S2.
    // All three stages may move in the same cycle, which is what allows one
    // request per cycle.
    assign s2_adv = !rsp_valid || rsp_ready;
    assign s1_adv = s1_valid && s2_adv;
    assign accept = !s1_valid || s2_adv;

    assign add_x = s1_x;
    assign add_y = s1_y;

    // ---------------------------------------------------------------------
    // Round-robin arbiter
    // ---------------------------------------------------------------------
    logic              found;
    logic [ID_W-1:0]   grant_idx;
    logic [IW1-1:0]    cand;
    logic              grant_vld;
    logic [ID_W-1:0]   ptr_next;

    // Search order is ptr, ptr+1, ... modulo NUM_REQ. The first valid
    // requester met in that order wins.
    always_comb begin
        found     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, ptr} + IW1'(k);
            if (cand >= IW1'(NUM_REQ)) begin
                cand = cand - IW1'(NUM_REQ);
            end
            if (!found && req_valid[cand[ID_W-1:0]]) begin
                found     = 1'b1;
                grant_idx = cand[ID_W-1:0];
            end
        end
    end

    assign grant_vld = found && accept && !rst;

    always_comb begin
        req_ready = '0;
        if (grant_vld) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // The wrap is written out explicitly, so non-power-of-two NUM_REQ
    // values still return to index 0.
    always_comb begin
        if (grant_idx == ID_W'(NUM_REQ - 1)) begin
            ptr_next = '0;
        end else begin
            ptr_next = grant_idx + ID_W'(1);
        end
    end

    // Operand and tag select for the granted requester. The mux uses
    // constant slices only.
    logic [31:0]      sel_x;
    logic [31:0]      sel_y;
    logic [TAG_W-1:0] sel_tag;

    always_comb begin
        sel_x   = '0;
        sel_y   = '0;
        sel_tag = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_x   = req_x[32*i +: 32];
                sel_y   = req_y[32*i +: 32];
                sel_tag = req_tag[TAG_W*i +: TAG_W];
            end
        end
    end

    // ---------------------------------------------------------------------
    // S1 / S2 registers and arbitration pointer
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_x      <= '0;
            s1_y      <= '0;
            s1_id     <= '0;
            s1_tag    <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_id    <= '0;
            rsp_tag   <= '0;
            ptr       <= '0;
        end else begin
            // S2: while it is stalled, the response payload is held.
            if (s2_adv) begin
                rsp_valid <= s1_valid;
                if (s1_adv) begin
                    rsp_data <= add_out;
                    rsp_id   <= s1_id;
                    rsp_tag  <= s1_tag;
                end
            end

            // S1: when accept is high, any old content has either moved to
            // S2 this cycle or was never valid. So S1 is either refilled by
            // the grant or left empty.
            if (accept) begin
                s1_valid <= grant_vld;
            end

            if (grant_vld) begin
                s1_x   <= sel_x;
                s1_y   <= sel_y;
                s1_id  <= grant_idx;
                s1_tag <= sel_tag;
                ptr    <= ptr_next;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Optional statistics
    // ---------------------------------------------------------------------
`ifdef F32ADD_RR_SHARE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_stall <= '0;
        end else begin
            if (rsp_valid && rsp_ready) begin
                stat_ops <= stat_ops + 32'd1;
            end
            if (rsp_valid && !rsp_ready) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters and no extra ports.
`endif

endmodule

// File: tb/tb_f32add_rr_share.sv
// -----------------------------------------------------------------------------
// Testbench for f32add_rr_share.
// The external shared adder is a behavioural f32 adder function: round to
// nearest even, denormals flushed, and every NaN result is 0x7FC00000.
// A negedge process predicts grants and responses from a queue-level model
// and compares the DUT against it on every cycle.
// -----------------------------------------------------------------------------
module tb_f32add_rr_share;

    localparam int NUM_REQ = 4;
    localparam int TAG_W   = 4;
    localparam int ID_W    = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic [NUM_REQ-1:0]       req_valid;
    logic [NUM_REQ-1:0]       req_ready;
    logic [32*NUM_REQ-1:0]    req_x;
    logic [32*NUM_REQ-1:0]    req_y;
    logic [TAG_W*NUM_REQ-1:0] req_tag;
    logic [31:0]              add_x;
    logic [31:0]              add_y;
    logic [31:0]              add_out;
    logic                     rsp_valid;
    logic                     rsp_ready;
    logic [ID_W-1:0]          rsp_id;
    logic [TAG_W-1:0]         rsp_tag;
    logic [31:0]              rsp_data;
`ifdef F32ADD_RR_SHARE_STATS_EN
    logic [31:0]              stat_ops;
    logic [31:0]              stat_stall;
`endif

    f32add_rr_share #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W), .ID_W(ID_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_tag   (req_tag),
        .add_x     (add_x),
        .add_y     (add_y),
        .add_out   (add_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_tag   (rsp_tag),
        .rsp_data  (rsp_data)
`ifdef F32ADD_RR_SHARE_STATS_EN
        ,
        .stat_ops  (stat_ops),
        .stat_stall(stat_stall)
`endif
    );

    // ---------------- reference f32 adder ----------------
    function automatic logic [31:0] f32_add(input logic [31:0] a, input logic [31:0] b);
        logic        sa, sb, sr, st, up, ts;
        int          ea, eb, er, d, te;
        logic [27:0] ma, mb, mr, tm;
        sa = a[31]; sb = b[31];
        ea = int'(a[30:23]); eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa == sb) ? a : 32'h7FC00000;
        if (ea == 255) return a;
        if (eb == 255) return b;
        if (ea == 0 && eb == 0) return {sa & sb, 31'b0};
        if (ea == 0) return b;
        if (eb == 0) return a;
        ma = {2'b01, a[22:0], 3'b000};
        mb = {2'b01, b[22:0], 3'b000};
        if (eb > ea || (eb == ea && mb > ma)) begin
            ts = sa; sa = sb; sb = ts;
            te = ea; ea = eb; eb = te;
            tm = ma; ma = mb; mb = tm;
        end
        d = ea - eb;
        if (d > 26) begin
            mb = 28'd1;
        end else if (d > 0) begin
            st = |(mb & ((28'd1 << d) - 28'd1));
            mb = (mb >> d) | {27'b0, st};
        end
        sr = sa; er = ea;
        if (sa == sb) begin
            mr = ma + mb;
            if (mr[27]) begin
                mr = (mr >> 1) | {27'b0, mr[0]};
                er++;
            end
        end else begin
            mr = ma - mb;
            if (mr == 0) return 32'h0;
            while (!mr[26]) begin
                mr = mr << 1;
                er--;
            end
        end
        if (er <= 0) return {sr, 31'b0};
        up = mr[2] && (mr[1] || mr[0] || mr[3]);
        mr = (mr >> 3) + {27'b0, up};
        if (mr[24]) begin
            mr = mr >> 1;
            er++;
        end
        if (er >= 255) return {sr, 8'hFF, 23'b0};
        return {sr, 8'(er), mr[22:0]};
    endfunction

    assign add_out = f32_add(add_x, add_y);

    // ---------------- scoreboard bookkeeping ----------------
    int n_total  = 0;
    int n_passed = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            n_passed++;
        end
    endtask

    typedef struct packed {
        logic [31:0]      k;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } exp_t;

    typedef struct packed {
        logic [31:0]      c;
        logic [ID_W-1:0]  id;
        logic [TAG_W-1:0] tag;
        logic [31:0]      data;
    } rsp_rec_t;

    typedef logic [64+TAG_W-1:0] stim_t;   // {x, y, tag}

    exp_t     exp_q[$];
    stim_t    stim_q[NUM_REQ][$];
    int       gnt_id[$];
    int       gnt_c[$];
    rsp_rec_t rsp_log[$];

    int       cyc     = 0;
    int       m_ptr   = 0;
    int       m_ops   = 0;
    int       m_stall = 0;

    // ---------------- driver tasks ----------------
    task automatic apply();
        stim_t s;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (stim_q[i].size() > 0) begin
                s = stim_q[i][0];
                req_valid[i]                = 1'b1;
                req_x[32*i +: 32]           = s[TAG_W+63 : TAG_W+32];
                req_y[32*i +: 32]           = s[TAG_W+31 : TAG_W];
                req_tag[TAG_W*i +: TAG_W]   = s[TAG_W-1:0];
            end else begin
                req_valid[i]                = 1'b0;
                req_x[32*i +: 32]           = '0;
                req_y[32*i +: 32]           = '0;
                req_tag[TAG_W*i +: TAG_W]   = '0;
            end
        end
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            apply();
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input int i, input logic [31:0] x, input logic [31:0] y, input logic [TAG_W-1:0] tag);
        stim_q[i].push_back({x, y, tag});
    endtask

    task automatic clear_stim();
        for (int i = 0; i < NUM_REQ; i++) stim_q[i].delete();
    endtask

    task automatic clear_logs();
        gnt_id.delete();
        gnt_c.delete();
        rsp_log.delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_stim();
        cycle(1);
        rst = 1'b0;
    endtask

    function automatic bit idle();
        bit r;
        r = (exp_q.size() == 0);
        for (int i = 0; i < NUM_REQ; i++) if (stim_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic wait_idle(input string name, input int max_cycles);
        int n;
        n = 0;
        while (!idle() && n < max_cycles) begin
            cycle(1);
            n++;
        end
        check({name, "_drain"}, 64'(idle()), 64'd1);
    endtask

    // ---------------- model + per-cycle compare ----------------
    bit               exp_rv;
    bit               m_acc;
    bit               m_found;
    int               m_g;
    logic [NUM_REQ-1:0] exp_rdy;

    always @(negedge clk) begin
        cyc++;
        exp_rv = (exp_q.size() > 0) && (cyc - int'(exp_q[0].k) >= 2);
        check("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
        if (exp_rv) begin
            check("rsp_data", 64'(rsp_data), 64'(exp_q[0].data));
            check("rsp_id",   64'(rsp_id),   64'(exp_q[0].id));
            check("rsp_tag",  64'(rsp_tag),  64'(exp_q[0].tag));
        end

        // At most two requests can be in flight. A third is accepted only
        // when the response at the head drains in the same cycle.
        m_acc   = !rst && (exp_q.size() < 2 || rsp_ready);
        m_found = 1'b0;
        m_g     = 0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!m_found && req_valid[(m_ptr + j) % NUM_REQ]) begin
                m_found = 1'b1;
                m_g     = (m_ptr + j) % NUM_REQ;
            end
        end
        exp_rdy = '0;
        if (m_acc && m_found) exp_rdy[m_g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(exp_rdy));

`ifdef F32ADD_RR_SHARE_STATS_EN
        check("stat_ops",   64'(stat_ops),   64'(m_ops));
        check("stat_stall", 64'(stat_stall), 64'(m_stall));
`endif

        if (!rst && rsp_valid && rsp_ready) begin
            rsp_log.push_back({32'(cyc), rsp_id, rsp_tag, rsp_data});
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i] && req_ready[i] && stim_q[i].size() > 0) void'(stim_q[i].pop_front());
        end

        if (rst) begin
            exp_q.delete();
            m_ptr   = 0;
            m_ops   = 0;
            m_stall = 0;
        end else begin
            if (exp_rv && rsp_ready) begin
                void'(exp_q.pop_front());
                m_ops++;
            end
            if (exp_rv && !rsp_ready) m_stall++;
            if (m_acc && m_found) begin
                exp_q.push_back({32'(cyc), ID_W'(m_g), req_tag[TAG_W*m_g +: TAG_W],
                                 f32_add(req_x[32*m_g +: 32], req_y[32*m_g +: 32])});
                gnt_id.push_back(m_g);
                gnt_c.push_back(cyc);
                m_ptr = (m_g + 1) % NUM_REQ;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed stimulus ----------------
    logic [31:0] vx[8];
    logic [31:0] vy[8];
    int          exp_order[8];
`ifdef F32ADD_RR_SHARE_STATS_EN
    logic [31:0] ops0;
`endif

    initial begin
        vx[0] = 32'h3F800000; vy[0] = 32'h40000000;
        vx[1] = 32'hC0400000; vy[1] = 32'h3FC00000;
        vx[2] = 32'h42C80000; vy[2] = 32'hC2C80000;
        vx[3] = 32'h3F800000; vy[3] = 32'h33800001;
        vx[4] = 32'h7F7FFFFF; vy[4] = 32'h7F7FFFFF;
        vx[5] = 32'h00400000; vy[5] = 32'h3F800000;
        vx[6] = 32'h3EAAAAAB; vy[6] = 32'h3F2AAAAB;
        vx[7] = 32'hBF800000; vy[7] = 32'hBF800000;

        // Hand-computed values that pin the reference adder.
        check("ref_1p2",      64'(f32_add(32'h3F800000, 32'h40000000)), 64'h40400000);
        check("ref_inf_ninf", 64'(f32_add(32'h7F800000, 32'hFF800000)), 64'h7FC00000);
        check("ref_tie_even", 64'(f32_add(32'h3F800000, 32'h33800000)), 64'h3F800000);
        check("ref_round_up", 64'(f32_add(32'h3F800000, 32'h33800001)), 64'h3F800001);
        check("ref_overflow", 64'(f32_add(32'h7F7FFFFF, 32'h7F7FFFFF)), 64'h7F800000);
        check("ref_denorm",   64'(f32_add(32'h00400000, 32'h3F800000)), 64'h3F800000);
        check("ref_cancel",   64'(f32_add(32'h42C80000, 32'hC2C80000)), 64'h00000000);
        check("ref_neg",      64'(f32_add(32'hBF800000, 32'hBF800000)), 64'hC0000000);

        // Reset values.
        rst       = 1'b1;
        rsp_ready = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        req_tag   = '0;
        cycle(2);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_add_x",     64'(add_x),     64'd0);
        check("rst_add_y",     64'(add_y),     64'd0);
        check("rst_rsp_data",  64'(rsp_data),  64'd0);
        check("rst_rsp_id",    64'(rsp_id),    64'd0);
        check("rst_rsp_tag",   64'(rsp_tag),   64'd0);
        check("rst_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        // Single request: 1.0 + 2.0 returns 3.0 two cycles later.
        clear_logs();
        rsp_ready = 1'b1;
        push(0, 32'h3F800000, 32'h40000000, 4'd5);
        wait_idle("single", 10);
        check("single_count", 64'(rsp_log.size()), 64'd1);
        if (rsp_log.size() == 1 && gnt_c.size() == 1) begin
            check("single_data",    64'(rsp_log[0].data), 64'h40400000);
            check("single_id",      64'(rsp_log[0].id),   64'd0);
            check("single_tag",     64'(rsp_log[0].tag),  64'd5);
            check("single_latency", 64'(int'(rsp_log[0].c) - gnt_c[0]), 64'd2);
        end

        // Fairness: all four requesters hold valid for eight grants.
        do_reset();
        clear_logs();
        rsp_ready = 1'b1;
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < NUM_REQ; i++)
                push(i, vx[r*4+i], vy[r*4+i], TAG_W'(r*4+i));
        wait_idle("fair", 30);
        exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
        check("fair_gnt_count", 64'(gnt_id.size()), 64'd8);
        check("fair_rsp_count", 64'(rsp_log.size()), 64'd8);
        if (gnt_id.size() == 8 && rsp_log.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                check($sformatf("fair_gnt%0d", j), 64'(gnt_id[j]), 64'(exp_order[j]));
                check($sformatf("fair_rsp_id%0d", j), 64'(rsp_log[j].id), 64'(exp_order[j]));
                if (j > 0) check($sformatf("fair_rate%0d", j), 64'(rsp_log[j].c - rsp_log[j-1].c), 64'd1);
            end
        end

        // Backpressure: three requests from requester 2, consumer stalled.
        clear_logs();
        rsp_ready = 1'b0;
        push(2, vx[6], vy[6], 4'd1);
        push(2, vx[1], vy[1], 4'd2);
        push(2, vx[3], vy[3], 4'd3);
        cycle(4);
        check("bp_accepts",   64'(gnt_id.size()),  64'd2);
        check("bp_no_rsp",    64'(rsp_log.size()), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid),      64'd1);
        check("bp_req_ready", 64'(req_ready),      64'd0);
        rsp_ready = 1'b1;
        wait_idle("bp", 10);
        check("bp_rsp_count", 64'(rsp_log.size()), 64'd3);
        if (rsp_log.size() == 3) begin
            for (int j = 0; j < 3; j++) begin
                check($sformatf("bp_tag%0d", j), 64'(rsp_log[j].tag), 64'(j + 1));
                check($sformatf("bp_id%0d", j),  64'(rsp_log[j].id),  64'd2);
            end
        end

        // Wrap: the pointer is now 3. Requesters 3 and 1 compete.
        clear_logs();
        push(3, vx[0], vy[0], 4'd4);
        push(3, vx[2], vy[2], 4'd5);
        push(1, vx[7], vy[7], 4'd6);
        wait_idle("wrap", 15);
        check("wrap_count", 64'(gnt_id.size()), 64'd3);
        if (gnt_id.size() == 3) begin
            check("wrap_g0", 64'(gnt_id[0]), 64'd3);
            check("wrap_g1", 64'(gnt_id[1]), 64'd1);
            check("wrap_g2", 64'(gnt_id[2]), 64'd3);
        end
        // The last grant was 3, so the pointer has wrapped to 0.
        clear_logs();
        push(3, vx[4], vy[4], 4'd7);
        push(0, vx[5], vy[5], 4'd8);
        wait_idle("wrap0", 10);
        if (gnt_id.size() == 2) begin
            check("wrap0_g0", 64'(gnt_id[0]), 64'd0);
            check("wrap0_g1", 64'(gnt_id[1]), 64'd3);
        end else begin
            check("wrap0_count", 64'(gnt_id.size()), 64'd2);
        end

        // Reset while S1 and S2 both hold requests.
        rsp_ready = 1'b0;
        push(1, vx[0], vy[0], 4'd9);
        push(1, vx[1], vy[1], 4'd10);
        push(1, vx[2], vy[2], 4'd11);
        cycle(3);
        check("mid_full", 64'(rsp_valid), 64'd1);
        rst = 1'b1;
        clear_stim();
        cycle(1);
        check("mid_rsp_valid", 64'(rsp_valid), 64'd0);
        check("mid_add_x",     64'(add_x),     64'd0);
        check("mid_add_y",     64'(add_y),     64'd0);
        rst = 1'b0;
        rsp_ready = 1'b1;
        clear_logs();
        push(2, vx[3], vy[3], 4'd13);
        push(0, vx[6], vy[6], 4'd12);
        wait_idle("mid", 10);
        check("mid_rsp_count", 64'(rsp_log.size()), 64'd2);
        if (gnt_id.size() > 0) check("mid_first_gnt", 64'(gnt_id[0]), 64'd0);
        if (rsp_log.size() == 2) begin
            check("mid_tag0", 64'(rsp_log[0].tag), 64'd12);
            check("mid_tag1", 64'(rsp_log[1].tag), 64'd13);
        end

        // Special values pass through to the adder untouched.
        clear_logs();
`ifdef F32ADD_RR_SHARE_STATS_EN
        ops0 = stat_ops;
`endif
        push(3, 32'h7F800000, 32'hFF800000, 4'd14);
        wait_idle("spec", 10);
        if (rsp_log.size() == 1) begin
            check("spec_nan", 64'(rsp_log[0].data), 64'h7FC00000);
        end else begin
            check("spec_count", 64'(rsp_log.size()), 64'd1);
        end
`ifdef F32ADD_RR_SHARE_STATS_EN
        check("spec_stat_ops", 64'(stat_ops), 64'(ops0 + 32'd1));
`endif
        clear_logs();
        push(0, 32'h7FC00001, 32'h3F800000, 4'd1);
        push(1, 32'h00000001, 32'h80000000, 4'd2);
        push(2, 32'h80000000, 32'h80000000, 4'd3);
        wait_idle("spec2", 12);
        if (rsp_log.size() == 3) check("spec_negzero", 64'(rsp_log[2].data), 64'h80000000);

        $display("%0d/%0d checks passed", n_passed, n_total);
        $finish;
    end

endmodule

// File: doc/f32add_rr_share.md
Name: f32add_rr_share

Overview:
- Shares one combinational f32 adder (IEEE-754 single, round-to-nearest-even, denormals flushed) between NUM_REQ requesters.
- Round-robin arbitration on valid/ready request channels.
- Registers the granted operands, drives them to the external adder, registers the sum and returns it on one response channel with requester ID and tag.
- Sits between requesting accelerator lanes and the shared f32add datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..16)
- TAG_W, 4, width of the opaque per-request tag
- ID_W, $clog2(NUM_REQ), width of the requester index

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_x  in  32*NUM_REQ  operand x, requester i at [32*i +: 32]
- req_y  in  32*NUM_REQ  operand y, same packing
- req_tag  in  TAG_W*NUM_REQ  tag, requester i at [TAG_W*i +: TAG_W]
- add_x  out  32  operand x to shared adder (registered)
- add_y  out  32  operand y to shared adder (registered)
- add_out  in  32  sum from shared adder (combinational function of add_x/add_y)
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumer ready
- rsp_id  out  ID_W  index of the requester that issued the response
- rsp_tag  out  TAG_W  tag echoed from the request
- rsp_data  out  32  f32 sum

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.

Pipeline:
- Two stages:
  - S1: operand register s1_x, s1_y, s1_id, s1_tag, s1_valid.
  - S2: result register rsp_data, rsp_id, rsp_tag, rsp_valid.
- add_x = s1_x and add_y = s1_y, driven straight from flops.
- Handshake rules:
  - s2_adv = !rsp_valid | rsp_ready
  - s1_adv = s1_valid & s2_adv (S2 captures add_out, s1_id, s1_tag)
  - accept = !s1_valid | s2_adv
- Latency: request handshake in cycle N gives rsp_valid high in cycle N+2 if rsp_ready stayed high.
- Throughput: one request per cycle with no backpressure.

Arbitration:
- Round-robin pointer ptr (ID_W bits) holds the highest-priority index. Search order: ptr, ptr+1, …, wrapping modulo NUM_REQ.
- grant = first valid requester in that order, taken only when accept=1. Otherwise grant=0.
- req_ready = grant (one-hot). req_ready may depend combinationally on req_valid, rsp_ready and state.
- On a handshake with requester g: ptr <= (g+1) mod NUM_REQ, with an explicit wrap at NUM_REQ-1 -> 0. ptr holds when there is no grant.
- Once a requester is granted, its operands and tag are latched into S1 in the same edge.

S2 data:
- S2 loads only when s2_adv.
- When rsp_valid=1 and rsp_ready=0, rsp_* are held stable and S1 holds.
- If S1 is also full, accept=0 and all req_ready stay 0.
- A simultaneous S2 drain, S1 advance and new grant in one cycle is legal and required for full throughput.

Reset:
- rst=1 at any edge clears s1_valid, rsp_valid and ptr to 0.
- In-flight requests are discarded, with no response.
- Reset values: rsp_data=0, rsp_id=0, rsp_tag=0, s1_x=s1_y=0 (so add_x=add_y=0).
- req_ready=0 while rst is high.

Special values:
- The block is value-agnostic: NaN, Inf, zero and denormal operands pass to the adder unmodified.
- add_out passes to rsp_data bit-exact.

Optional Feature:
- Macro: F32ADD_RR_SHARE_STATS_EN.
- When defined, adds two outputs:
  - stat_ops (32b): count of completed response handshakes.
  - stat_stall (32b): count of cycles with rsp_valid & !rsp_ready.
- Both counters wrap at 2^32, clear on rst, and are registered outputs.
- When undefined, the ports and counters do not exist and behaviour is otherwise identical.

Test Plan:
- Single request: requester 0 sends x=0x3F800000, y=0x40000000, tag=5, rsp_ready=1 -> cycle N+2 gives rsp_valid=1, rsp_data=0x40400000, rsp_id=0, rsp_tag=5.
- Fairness: all 4 requesters hold valid for 8 cycles -> grant order 0,1,2,3,0,1,2,3, one response per cycle, ids in the same order.
- Backpressure: 3 back-to-back requests from requester 2 with rsp_ready=0 for 4 cycles -> first response held stable, all req_ready=0 after 2 accepts. After rsp_ready=1, all 3 responses arrive in order with no loss or duplication.
- Wrap/pointer: only requesters 3 and 1 valid with ptr=3 -> grants 3, then 1, then 3. ptr wraps 3 -> 0 correctly.
- Reset mid-flight: assert rst for 1 cycle while S1 and S2 are both valid -> next cycle rsp_valid=0, add_x=0, and no stale response ever appears. The next request from requester 0 is granted first.
- Special values: x=0x7F800000, y=0xFF800000 -> rsp_data equals the adder output 0x7FC00000. With STATS_EN, stat_ops increments by 1.
